hazard_ctrl_unit: RTL and testbench
===================================

Name: hazard_ctrl_unit

Overview:
Parametrised pipeline hazard controller for the RV32I 5-stage core, supporting N operand sources. It provides EX-stage forwarding selects, load-use stalls, stalls for variable-latency data-memory responses, and multi-cycle branch flushes. A small FSM tracks outstanding loads and flush windows. Saturating performance counters record stall cycles and flush events. It sits beside the ID/EX and EX/MEM pipeline registers.

Parameters:
NUM_SRC, 2, number of source operands checked per instruction (1..3)
REG_AW, 5, register address width
FLUSH_CYCLES, 2, cycles flush stays high per taken branch (>=1)
MEM_TIMEOUT, 16, max cycles waiting for mem_rsp_valid before error
CNT_W, 32, performance counter width

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
id_ex_rs  in  NUM_SRC*REG_AW  packed source addresses; src i at [i*REG_AW +: REG_AW]
id_ex_rs_used  in  NUM_SRC  source i actually read by instruction
ex_mem_rd  in  REG_AW  EX/MEM destination
ex_mem_regwrite  in  1  EX/MEM writes rd
ex_mem_memread  in  1  EX/MEM is a load
mem_wb_rd  in  REG_AW  MEM/WB destination
mem_wb_regwrite  in  1  MEM/WB writes rd
mem_req_valid  in  1  load request issued from MEM this cycle
mem_rsp_valid  in  1  load data returned this cycle
branch_taken  in  1  branch/jump resolved taken in EX (single-cycle pulse)
forward_sel  out  2*NUM_SRC  per source: 00 regfile, 10 EX/MEM, 01 MEM/WB
stall  out  1  freeze PC, IF/ID, ID/EX
flush  out  1  squash younger stages
mem_timeout_err  out  1  sticky; set on MEM_TIMEOUT expiry
stall_cnt  out  CNT_W  cycles with stall=1
flush_cnt  out  CNT_W  flush events

Behaviour:
- Reset (synchronous, rst=1 at posedge): state=IDLE, flush counter=0, pending_branch=0, mem_timeout_err=0, stall_cnt=0, flush_cnt=0. Reset mid-load or mid-flush aborts it immediately. Combinational outputs read 0 from the cycle after reset, given idle inputs.
- Forwarding (combinational, per source i): src i matches a stage when id_ex_rs_used[i]=1, the stage regwrite=1, rd!=0 and rd==rs_i.
  - EX/MEM match with ex_mem_memread=0 -> 10.
  - Otherwise MEM/WB match -> 01.
  - Otherwise 00.
  - EX/MEM has priority. A load in EX/MEM never forwards.
- load_use (combinational): ex_mem_memread & ex_mem_regwrite & rd!=0 & rd matches any used source.
- FSM states: IDLE, LOAD_WAIT, FLUSH.
  - IDLE: if mem_req_valid & !mem_rsp_valid, go to LOAD_WAIT and clear the wait counter. Else if a flush is issued this cycle and FLUSH_CYCLES>1, go to FLUSH with counter=FLUSH_CYCLES-1.
  - LOAD_WAIT: if mem_rsp_valid, go to IDLE, or to FLUSH if a pending branch flushes this cycle and FLUSH_CYCLES>1. If the wait counter reaches MEM_TIMEOUT-1, set mem_timeout_err and go to IDLE.
  - FLUSH: decrement the counter; at 1 go to IDLE. branch_taken is ignored here because the branch is itself being squashed.
- stall = load_use | (IDLE & mem_req_valid & !mem_rsp_valid) | (LOAD_WAIT & !mem_rsp_valid).
- flush = (state==FLUSH) | (!stall & (branch_taken | pending_branch)). Stall has priority over flush.
- branch_taken while stall=1 sets pending_branch. pending_branch clears on the cycle flush is issued.
- stall_cnt increments each cycle stall=1.
- flush_cnt increments once per flush event, i.e. on the first flush cycle only.
- Both counters saturate at all-ones.

Decomposition:
- Shared package hazard_pkg: forward_sel encodings (FWD_RF=2'b00, FWD_EXMEM=2'b10, FWD_MEMWB=2'b01) and the FSM state typedef.
- One sub-module, hazard_fwd_mux_sel: per-source forwarding compare, instantiated NUM_SRC times via generate.

Test Plan:
1. rs0=5, rs1=5, ex_mem_rd=5 (regwrite, not load), mem_wb_rd=5 (regwrite) -> forward_sel=4'b1010; with ex_mem_rd=0 instead -> 4'b0101.
2. ex_mem load with rd=7, rs1=7 used -> stall=1 and forward_sel src1=00. With id_ex_rs_used[1]=0 -> stall=0.
3. mem_req_valid, then mem_rsp_valid 4 cycles later -> stall high for exactly 4 cycles, stall_cnt=4, state returns to IDLE.
4. branch_taken pulse in IDLE, FLUSH_CYCLES=2 -> flush high 2 cycles, flush_cnt=1. A second branch_taken on cycle 2 is ignored.
5. branch_taken during LOAD_WAIT -> no flush while stalled; flush rises on the mem_rsp_valid cycle and holds 2 cycles.
6. mem_req_valid with no response (MEM_TIMEOUT=16) -> stall for 16 cycles, then mem_timeout_err=1 and stall=0. rst asserted mid-wait -> all outputs and counters 0 next cycle.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding selects and
// the FSM state type.
package hazard_pkg;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    typedef enum logic [1:0] {
        IDLE,
        LOAD_WAIT,
        FLUSH
    } hazard_state_t;

endpackage

// File: rtl/hazard_fwd_mux_sel.sv
// Per-source forwarding compare: picks the operand source for one EX-stage
// operand and flags a load-use hit against the load sitting in EX/MEM.
module hazard_fwd_mux_sel
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs,
    input  logic              used,
    input  logic [REG_AW-1:0] ex_mem_rd,
    input  logic              ex_mem_regwrite,
    input  logic              ex_mem_memread,
    input  logic [REG_AW-1:0] mem_wb_rd,
    input  logic              mem_wb_regwrite,
    output logic [1:0]        sel,
    output logic              load_hit
);

    logic ex_match;
    logic wb_match;

    // x0 is hardwired to zero, so a write to it is never a real producer.
    assign ex_match = used && ex_mem_regwrite && (ex_mem_rd != '0) && (ex_mem_rd == rs);
    assign wb_match = used && mem_wb_regwrite && (mem_wb_rd != '0) && (mem_wb_rd == rs);

    // A load in EX/MEM has no data yet; it stalls instead of forwarding.
    assign load_hit = ex_match && ex_mem_memread;

    always_comb begin
        // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
        sel = FWD_RF;
        if (ex_match && !ex_mem_memread) begin
            sel = FWD_EXMEM;
        end else if (wb_match) begin
            sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard controller for the 5-stage core: operand forwarding, load-use and
// memory-wait stalls, multi-cycle branch flushes and saturating perf counters.
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int NUM_SRC      = 2,
    parameter int REG_AW       = 5,
    parameter int FLUSH_CYCLES = 2,
    parameter int MEM_TIMEOUT  = 16,
    parameter int CNT_W        = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC*REG_AW-1:0] id_ex_rs,
    input  logic [NUM_SRC-1:0]        id_ex_rs_used,
    input  logic [REG_AW-1:0]         ex_mem_rd,
    input  logic                      ex_mem_regwrite,
    input  logic                      ex_mem_memread,
    input  logic [REG_AW-1:0]         mem_wb_rd,
    input  logic                      mem_wb_regwrite,
    input  logic                      mem_req_valid,
    input  logic                      mem_rsp_valid,
    input  logic                      branch_taken,
    output logic [2*NUM_SRC-1:0]      forward_sel,
    output logic                      stall,
    output logic                      flush,
    output logic                      mem_timeout_err,
    output logic [CNT_W-1:0]          stall_cnt,
    output logic [CNT_W-1:0]          flush_cnt
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT) + 1;
    localparam int FL_W   = $clog2(FLUSH_CYCLES) + 1;

    hazard_state_t     state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic [FL_W-1:0]   flush_left, flush_left_nxt;
    logic              pending_branch, pending_branch_nxt;
    logic              timeout_hit;
    logic [NUM_SRC-1:0] load_hit;
    logic              load_use;
    logic              flush_issue;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        hazard_fwd_mux_sel #(.REG_AW(REG_AW)) u_sel (
            .rs              (id_ex_rs[i*REG_AW +: REG_AW]),
            .used            (id_ex_rs_used[i]),
            .ex_mem_rd       (ex_mem_rd),
            .ex_mem_regwrite (ex_mem_regwrite),
            .ex_mem_memread  (ex_mem_memread),
            .mem_wb_rd       (mem_wb_rd),
            .mem_wb_regwrite (mem_wb_regwrite),
            .sel             (forward_sel[2*i +: 2]),
            .load_hit        (load_hit[i])
        );
    end

    assign load_use = |load_hit;

    assign stall = load_use
                || ((state == IDLE) && mem_req_valid && !mem_rsp_valid)
                || ((state == LOAD_WAIT) && !mem_rsp_valid);

    // A flush already in progress squashes any branch that resolves under it.
    assign flush_issue = (state != FLUSH) && !stall && (branch_taken || pending_branch);
    assign flush       = (state == FLUSH) || flush_issue;

    assign pending_branch_nxt = flush ? 1'b0 : (pending_branch || (branch_taken && stall));

    always_comb begin
        state_nxt      = state;
        wait_cnt_nxt   = wait_cnt;
        flush_left_nxt = flush_left;
        timeout_hit    = 1'b0;
        case (state)
            IDLE: begin
                if (mem_req_valid && !mem_rsp_valid) begin
                    state_nxt    = LOAD_WAIT;
                    wait_cnt_nxt = '0;
                end else if (flush_issue && (FLUSH_CYCLES > 1)) begin
                    state_nxt      = FLUSH;
                    flush_left_nxt = FL_W'(FLUSH_CYCLES - 1);
                end
            end
            LOAD_WAIT: begin
                if (mem_rsp_valid) begin
                    state_nxt = IDLE;
                    if (flush_issue && (FLUSH_CYCLES > 1)) begin
                        state_nxt      = FLUSH;
                        flush_left_nxt = FL_W'(FLUSH_CYCLES - 1);
                    end
                // Counter is about to reach MEM_TIMEOUT-1: the request cycle
                // plus these wait cycles make MEM_TIMEOUT stalled cycles.
                end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 2)) begin
                    state_nxt   = IDLE;
                    timeout_hit = 1'b1;
                end else begin
                    wait_cnt_nxt = wait_cnt + WAIT_W'(1);
                end
            end
            FLUSH: begin
                if (flush_left <= FL_W'(1)) begin
                    state_nxt = IDLE;
                end else begin
                    flush_left_nxt = flush_left - FL_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state           <= IDLE;
            wait_cnt        <= '0;
            flush_left      <= '0;
            pending_branch  <= 1'b0;
            mem_timeout_err <= 1'b0;
            stall_cnt       <= '0;
            flush_cnt       <= '0;
        end else begin
            state          <= state_nxt;
            wait_cnt       <= wait_cnt_nxt;
            flush_left     <= flush_left_nxt;
            pending_branch <= pending_branch_nxt;
            if (timeout_hit) begin
                mem_timeout_err <= 1'b1;
            end
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush_issue && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Self-checking bench for hazard_ctrl_unit: directed scenarios plus a long
// randomized run compared against a cycle-level behavioural model.
module tb_hazard_ctrl_unit;

    localparam int NUM_SRC      = 2;
    localparam int REG_AW       = 5;
    localparam int FLUSH_CYCLES = 2;
    localparam int MEM_TIMEOUT  = 16;
    localparam int CNT_W        = 32;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_SRC*REG_AW-1:0] id_ex_rs;
    logic [NUM_SRC-1:0]        id_ex_rs_used;
    logic [REG_AW-1:0]         ex_mem_rd;
    logic                      ex_mem_regwrite;
    logic                      ex_mem_memread;
    logic [REG_AW-1:0]         mem_wb_rd;
    logic                      mem_wb_regwrite;
    logic                      mem_req_valid;
    logic                      mem_rsp_valid;
    logic                      branch_taken;
    logic [2*NUM_SRC-1:0]      forward_sel;
    logic                      stall;
    logic                      flush;
    logic                      mem_timeout_err;
    logic [CNT_W-1:0]          stall_cnt;
    logic [CNT_W-1:0]          flush_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    hazard_ctrl_unit #(
        .NUM_SRC(NUM_SRC), .REG_AW(REG_AW), .FLUSH_CYCLES(FLUSH_CYCLES),
        .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .id_ex_rs(id_ex_rs), .id_ex_rs_used(id_ex_rs_used),
        .ex_mem_rd(ex_mem_rd), .ex_mem_regwrite(ex_mem_regwrite), .ex_mem_memread(ex_mem_memread),
        .mem_wb_rd(mem_wb_rd), .mem_wb_regwrite(mem_wb_regwrite),
        .mem_req_valid(mem_req_valid), .mem_rsp_valid(mem_rsp_valid), .branch_taken(branch_taken),
        .forward_sel(forward_sel), .stall(stall), .flush(flush),
        .mem_timeout_err(mem_timeout_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_ex_rs        = '0;
        id_ex_rs_used   = '0;
        ex_mem_rd       = '0;
        ex_mem_regwrite = 1'b0;
        ex_mem_memread  = 1'b0;
        mem_wb_rd       = '0;
        mem_wb_regwrite = 1'b0;
        mem_req_valid   = 1'b0;
        mem_rsp_valid   = 1'b0;
        branch_taken    = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        // Leave some state behind first so reset has something to clear.
        idle_inputs();
        rst = 1'b0;
        branch_taken = 1'b1;
        tick();
        branch_taken = 1'b0;
        do_reset();
        n_checks++;
        if ({forward_sel, stall, flush, mem_timeout_err} !== '0 || stall_cnt !== '0 || flush_cnt !== '0)
            $display("FAIL reset_state: fwd=%b stall=%b flush=%b err=%b scnt=%0d fcnt=%0d, all required 0",
                     forward_sel, stall, flush, mem_timeout_err, stall_cnt, flush_cnt);
        else n_pass++;
    endtask

    task automatic test_forwarding();
        logic [1:0] exp_sel [NUM_SRC];
        logic [REG_AW-1:0] rs_v [NUM_SRC];
        logic [2*NUM_SRC-1:0] exp_all;
        logic exp_lu;
        do_reset();
        id_ex_rs = {5'd5, 5'd5};
        id_ex_rs_used = 2'b11;
        ex_mem_rd = 5'd5; ex_mem_regwrite = 1'b1;
        mem_wb_rd = 5'd5; mem_wb_regwrite = 1'b1;
        #1;
        n_checks++;
        if (forward_sel !== 4'b1010) $display("FAIL fwd_exmem_priority: got %b required %b", forward_sel, 4'b1010);
        else n_pass++;
        ex_mem_rd = 5'd0;
        #1;
        n_checks++;
        if (forward_sel !== 4'b0101) $display("FAIL fwd_memwb_x0: got %b required %b", forward_sel, 4'b0101);
        else n_pass++;

        for (int k = 0; k < 60; k++) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                rs_v[i] = REG_AW'($urandom_range(0, 3));
                id_ex_rs[i*REG_AW +: REG_AW] = rs_v[i];
            end
            id_ex_rs_used   = NUM_SRC'($urandom);
            ex_mem_rd       = REG_AW'($urandom_range(0, 3));
            ex_mem_regwrite = 1'($urandom);
            ex_mem_memread  = ($urandom_range(0, 3) == 0);
            mem_wb_rd       = REG_AW'($urandom_range(0, 3));
            mem_wb_regwrite = 1'($urandom);
            #1;
            exp_lu = 1'b0;
            for (int i = 0; i < NUM_SRC; i++) begin
                if (id_ex_rs_used[i] && ex_mem_regwrite && ex_mem_rd != 0 && ex_mem_rd == rs_v[i] && !ex_mem_memread)
                    exp_sel[i] = 2'b10;
                else if (id_ex_rs_used[i] && mem_wb_regwrite && mem_wb_rd != 0 && mem_wb_rd == rs_v[i])
                    exp_sel[i] = 2'b01;
                else
                    exp_sel[i] = 2'b00;
                if (id_ex_rs_used[i] && ex_mem_regwrite && ex_mem_memread && ex_mem_rd != 0 && ex_mem_rd == rs_v[i])
                    exp_lu = 1'b1;
                exp_all[2*i +: 2] = exp_sel[i];
            end
            n_checks++;
            if (forward_sel !== exp_all || stall !== exp_lu)
                $display("FAIL fwd_random[%0d]: got sel=%b stall=%b required sel=%b stall=%b",
                         k, forward_sel, stall, exp_all, exp_lu);
            else n_pass++;
        end
    endtask

    task automatic test_load_use();
        do_reset();
        id_ex_rs = {5'd7, 5'd3};
        id_ex_rs_used = 2'b11;
        ex_mem_rd = 5'd7; ex_mem_regwrite = 1'b1; ex_mem_memread = 1'b1;
        #1;
        n_checks++;
        if (stall !== 1'b1 || forward_sel[3:2] !== 2'b00)
            $display("FAIL load_use_stall: got stall=%b src1=%b required stall=1 src1=00", stall, forward_sel[3:2]);
        else n_pass++;
        id_ex_rs_used = 2'b01;
        #1;
        n_checks++;
        if (stall !== 1'b0) $display("FAIL load_use_unused_src: got stall=%b required 0", stall);
        else n_pass++;
    endtask

    task automatic test_mem_wait();
        int stalled = 0;
        do_reset();
        mem_req_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (c == 4) mem_rsp_valid = 1'b1;
            #1;
            if (stall) stalled++;
            tick();
            mem_req_valid = 1'b0;
            mem_rsp_valid = 1'b0;
        end
        #1;
        n_checks++;
        if (stalled != 4 || stall_cnt !== 32'd4 || stall !== 1'b0)
            $display("FAIL mem_wait: stall cycles=%0d stall_cnt=%0d stall_after=%b required 4/4/0",
                     stalled, stall_cnt, stall);
        else n_pass++;
    endtask

    task automatic test_branch_flush();
        logic [2:0] seen;
        do_reset();
        branch_taken = 1'b1;
        #1; seen[0] = flush;
        tick();
        branch_taken = 1'b1;
        #1; seen[1] = flush;
        tick();
        branch_taken = 1'b0;
        #1; seen[2] = flush;
        n_checks++;
        if (seen !== 3'b011) $display("FAIL branch_flush_window: got %b required %b", seen, 3'b011);
        else n_pass++;
        n_checks++;
        if (flush_cnt !== 32'd1) $display("FAIL branch_flush_cnt: got %0d required 1", flush_cnt);
        else n_pass++;
    endtask

    task automatic test_branch_during_load();
        logic [5:0] seen;
        do_reset();
        mem_req_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            branch_taken  = (c == 1);
            mem_rsp_valid = (c == 3);
            #1;
            seen[c] = flush;
            tick();
            mem_req_valid = 1'b0;
        end
        branch_taken = 1'b0;
        mem_rsp_valid = 1'b0;
        #1;
        n_checks++;
        if (seen !== 6'b011000) $display("FAIL branch_in_load: flush trace=%b required %b", seen, 6'b011000);
        else n_pass++;
        n_checks++;
        if (flush_cnt !== 32'd1 || stall_cnt !== 32'd3)
            $display("FAIL branch_in_load_cnts: fcnt=%0d scnt=%0d required 1/3", flush_cnt, stall_cnt);
        else n_pass++;
    endtask

    task automatic test_timeout_and_reset();
        int stalled = 0;
        do_reset();
        mem_req_valid = 1'b1;
        for (int c = 0; c < 3 * MEM_TIMEOUT; c++) begin
            #1;
            if (!stall) break;
            stalled++;
            tick();
            mem_req_valid = 1'b0;
        end
        n_checks++;
        if (stalled != MEM_TIMEOUT || mem_timeout_err !== 1'b1 || stall_cnt !== CNT_W'(MEM_TIMEOUT))
            $display("FAIL mem_timeout: stall cycles=%0d err=%b stall_cnt=%0d required %0d/1/%0d",
                     stalled, mem_timeout_err, stall_cnt, MEM_TIMEOUT, MEM_TIMEOUT);
        else n_pass++;

        // Reset in the middle of a wait with a branch parked behind it.
        mem_req_valid = 1'b1;
        tick();
        mem_req_valid = 1'b0;
        branch_taken = 1'b1;
        tick();
        branch_taken = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        n_checks++;
        if ({stall, flush, mem_timeout_err} !== 3'b000 || stall_cnt !== '0 || flush_cnt !== '0)
            $display("FAIL reset_mid_wait: stall=%b flush=%b err=%b scnt=%0d fcnt=%0d required all 0",
                     stall, flush, mem_timeout_err, stall_cnt, flush_cnt);
        else n_pass++;
        tick();
        n_checks++;
        if (flush !== 1'b0 || stall !== 1'b0)
            $display("FAIL reset_drops_pending: flush=%b stall=%b required 0/0", flush, stall);
        else n_pass++;
    endtask

    task automatic test_random();
        // Model state: whether a load is outstanding and how long ago it was
        // issued, how many further flush cycles remain, and a parked branch.
        bit      m_waiting, m_pending, m_err;
        int      m_age, m_flush_rem;
        longint  m_scnt, m_fcnt;
        bit      m_lu, m_stall, m_new_flush, m_flush;
        logic [1:0] e_sel;
        logic [2*NUM_SRC-1:0] e_fwd;
        logic [REG_AW-1:0] rs_v [NUM_SRC];
        int      errs = 0;
        do_reset();
        m_waiting = 0; m_pending = 0; m_err = 0; m_age = 0; m_flush_rem = 0; m_scnt = 0; m_fcnt = 0;
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                rs_v[i] = REG_AW'($urandom_range(0, 3));
                id_ex_rs[i*REG_AW +: REG_AW] = rs_v[i];
            end
            id_ex_rs_used   = NUM_SRC'($urandom);
            ex_mem_rd       = REG_AW'($urandom_range(0, 3));
            ex_mem_regwrite = 1'($urandom);
            ex_mem_memread  = ($urandom_range(0, 9) < 2);
            mem_wb_rd       = REG_AW'($urandom_range(0, 3));
            mem_wb_regwrite = 1'($urandom);
            mem_req_valid   = ($urandom_range(0, 99) < 15);
            mem_rsp_valid   = ($urandom_range(0, 99) < 10);
            branch_taken    = ($urandom_range(0, 99) < 15);
            rst             = ($urandom_range(0, 199) == 0);
            #1;
            m_lu = 0;
            for (int i = 0; i < NUM_SRC; i++) begin
                e_sel = 2'b00;
                if (id_ex_rs_used[i] && ex_mem_regwrite && ex_mem_rd != 0 && ex_mem_rd == rs_v[i]) begin
                    if (ex_mem_memread) m_lu = 1;
                    else e_sel = 2'b10;
                end
                if (e_sel == 2'b00 && id_ex_rs_used[i] && mem_wb_regwrite && mem_wb_rd != 0 && mem_wb_rd == rs_v[i])
                    e_sel = 2'b01;
                e_fwd[2*i +: 2] = e_sel;
            end
            m_stall = m_lu || (m_flush_rem == 0 && !m_waiting && mem_req_valid && !mem_rsp_valid)
                           || (m_waiting && !mem_rsp_valid);
            m_new_flush = (m_flush_rem == 0) && !m_stall && (branch_taken || m_pending);
            m_flush = (m_flush_rem > 0) || m_new_flush;

            n_checks++;
            if (forward_sel !== e_fwd || stall !== m_stall || flush !== m_flush) begin
                if (errs < 10) $display("FAIL rand_ctrl[%0d]: got sel=%b stall=%b flush=%b required sel=%b stall=%b flush=%b",
                                        k, forward_sel, stall, flush, e_fwd, m_stall, m_flush);
                errs++;
            end else n_pass++;
            n_checks++;
            if (mem_timeout_err !== m_err || stall_cnt !== CNT_W'(m_scnt) || flush_cnt !== CNT_W'(m_fcnt)) begin
                if (errs < 10) $display("FAIL rand_status[%0d]: got err=%b scnt=%0d fcnt=%0d required err=%b scnt=%0d fcnt=%0d",
                                        k, mem_timeout_err, stall_cnt, flush_cnt, m_err, m_scnt, m_fcnt);
                errs++;
            end else n_pass++;

            if (rst) begin
                m_waiting = 0; m_pending = 0; m_err = 0; m_age = 0; m_flush_rem = 0; m_scnt = 0; m_fcnt = 0;
            end else begin
                if (m_flush_rem > 0) begin
                    m_flush_rem--;
                end else if (m_waiting) begin
                    if (mem_rsp_valid) begin
                        m_waiting = 0;
                        if (m_new_flush) m_flush_rem = FLUSH_CYCLES - 1;
                    end else if (m_age == MEM_TIMEOUT - 1) begin
                        m_waiting = 0;
                        m_err = 1;
                    end else begin
                        m_age++;
                    end
                end else if (mem_req_valid && !mem_rsp_valid) begin
                    m_waiting = 1;
                    m_age = 1;
                end else if (m_new_flush) begin
                    m_flush_rem = FLUSH_CYCLES - 1;
                end
                m_pending = m_flush ? 0 : (m_pending || (branch_taken && m_stall));
                if (m_stall) m_scnt++;
                if (m_new_flush) m_fcnt++;
            end
            tick();
        end
        rst = 1'b0;
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        tick();
        test_reset();
        test_forwarding();
        test_load_use();
        test_mem_wait();
        test_branch_flush();
        test_branch_during_load();
        test_timeout_and_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
